hack_screen_wq: RTL and testbench
=================================

Name: hack_screen_wq

Overview:
- Screen write queue. Sits directly downstream of the 4-way load demultiplexer in the Hack memory map. Consumes the screen-region load strobe (address bits [14:13] = 2'b10) together with the 13-bit screen offset and the 16-bit data word.
- Buffers CPU screen writes in a small FIFO and drains them to the framebuffer write port over a valid/ready handshake.
- The CPU need not stall unless the queue is full.

Parameters:
- DEPTH, 8, number of queue entries; power of two, minimum 2.
- AW, 13, screen word-address width (8K words).
- DW, 16, data word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  screen write strobe (demux output for the screen region).
- addr  input  AW  screen word offset for the write.
- in  input  DW  write data.
- stall  output  1  queue full; CPU must hold its write.
- fb_valid  output  1  head entry is available.
- fb_addr  output  AW  head entry address.
- fb_data  output  DW  head entry data.
- fb_ready  input  1  framebuffer accepts the head entry this cycle.
- ovf  output  1  sticky flag: a write was dropped.
- ovf_clr  input  1  clears ovf.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: count=0, rd_ptr=0, wr_ptr=0, ovf=0. Therefore fb_valid=0 and stall=0. fb_addr/fb_data are don't-care while fb_valid=0; the bench must not check them.
- Storage: array of {addr, data} entries, DEPTH deep. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- fb_valid = (count != 0).
- fb_addr/fb_data are combinational reads of entry[rd_ptr].
- stall = (count == DEPTH), combinational from registered count.
- pop = fb_valid & fb_ready.
- push = load & (count != DEPTH | pop). A push while full is allowed only with a simultaneous pop.
- Latency: a load accepted at edge N is visible on fb_valid after edge N. There is no same-cycle bypass, so the minimum is 1 cycle from load to fb_valid.
- Simultaneous push and pop: count is unchanged, both pointers advance. This holds for any count, including full.
- Order: entries drain strictly FIFO.
- Drop: load while full with no pop. The write is discarded, state is unchanged, and ovf is set at the next edge.
- ovf: set by a drop, cleared by ovf_clr or reset. If ovf_clr and a drop occur in the same cycle, set wins.
- fb_ready while empty: ignored, no state change.
- fb_data/fb_addr must hold stable while fb_valid=1 and fb_ready=0.
- Reset mid-operation: all queued entries are discarded, no partial drain, and ovf is cleared.

Optional Feature:
- Macro: HACK_SCREEN_WQ_COALESCE_EN.
- Defined: if load and count>0 and addr equals the tail entry address (entry[wr_ptr-1]), the tail entry's data is overwritten in place.
  - No push occurs; count and wr_ptr are unchanged.
  - This applies even when full: no drop, ovf is not set.
  - Exception: if the tail is also the head and is popped this cycle (count==1 & pop), a normal push occurs instead.
- Undefined: every accepted load is a separate entry.

Decomposition:
- Package hack_pkg:
  - HACK_WORD_W=16, HACK_SCREEN_AW=13.
  - HACK_SCREEN_SEL=2'b10.
  - Typedef hack_wq_entry_t {addr, data}.
- Sub-module hack_wq_mem: DEPTH-entry register array with one write port and one async read port, holding the pointer-indexed storage. Pointer, count and flag logic stay in hack_screen_wq.

Test Plan:
- Reset, then idle 5 cycles -> fb_valid=0, stall=0, ovf=0.
- load addr=0x0010 in=0xBEEF with fb_ready=1 -> fb_valid=1 next cycle with fb_addr=0x0010, fb_data=0xBEEF; popped that cycle; fb_valid=0 after.
- fb_ready=0, 8 loads addr=i, data=0x1000+i -> stall=1 after 8th. 9th load -> dropped, ovf=1. Then fb_ready=1 -> drains 0x1000..0x1007 in order, no 0x1008. ovf_clr -> ovf=0.
- Full queue, load addr=0x1FFF data=0xAAAA with fb_ready=1 same cycle -> count stays 8, no ovf; 0xAAAA emerges 8th after the current head.
- fb_ready toggles 1/0 each cycle during a 20-write burst -> outputs stable while fb_ready=0, exact in-order sequence, pointer wrap correct.
- With HACK_SCREEN_WQ_COALESCE_EN: fb_ready=0, writes (0x20,0x1111), (0x20,0x2222), (0x21,0x3333) -> 2 entries, draining (0x20,0x2222) then (0x21,0x3333). Without the macro: 3 entries.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack memory-map constants and the screen write-queue entry type.
package hack_pkg;

    localparam int HACK_WORD_W    = 16;
    localparam int HACK_SCREEN_AW = 13;

    localparam logic [1:0] HACK_SCREEN_SEL = 2'b10;

    typedef struct packed {
        logic [HACK_SCREEN_AW-1:0] addr;
        logic [HACK_WORD_W-1:0]    data;
    } hack_wq_entry_t;

endpackage

// File: rtl/hack_wq_mem.sv
// DEPTH-entry register array for the screen write queue: one write port,
// one asynchronous read port.
module hack_wq_mem
    import hack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = HACK_SCREEN_AW + HACK_WORD_W,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Storage write port; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/hack_screen_wq.sv
// Screen write queue: buffers CPU screen writes and drains them over valid/ready.
// Optional tail-write coalescing is enabled by defining HACK_SCREEN_WQ_COALESCE_EN.
module hack_screen_wq
    import hack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = HACK_SCREEN_AW,
    parameter int DW    = HACK_WORD_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] in,
    output logic          stall,
    output logic          fb_valid,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_data,
    input  logic          fb_ready,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             ovf_r;

    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             coal_s;
    logic [PW-1:0]    wr_idx_s;
    logic [AW+DW-1:0] rd_data_s;

    assign full_s   = (count_r == FULL_CNT);
    assign fb_valid = (count_r != {CW{1'b0}});
    assign stall    = full_s;
    assign ovf      = ovf_r;
    assign pop_s    = fb_valid & fb_ready;

`ifdef HACK_SCREEN_WQ_COALESCE_EN
    // Shadow of the tail entry address, so the array keeps a single read port.
    logic [AW-1:0] tail_addr_r;

    // A popped sole entry cannot absorb a write; that case pushes normally.
    assign coal_s = load & fb_valid & (addr == tail_addr_r)
                  & ~((count_r == ONE_CNT) & pop_s);

    // Track the address of the most recently pushed entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tail_addr_r <= {AW{1'b0}};
        end else if (push_s) begin
            tail_addr_r <= addr;
        end else begin
            tail_addr_r <= tail_addr_r;
        end
    end
`else
    assign coal_s = 1'b0;
`endif

    assign push_s   = load & ~coal_s & (~full_s | pop_s);
    assign drop_s   = load & ~coal_s & full_s & ~pop_s;
    assign wr_idx_s = coal_s ? (wr_ptr_r - PW'(1)) : wr_ptr_r;

    hack_wq_mem #(
        .DEPTH (DEPTH),
        .W     (AW + DW),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s | coal_s),
        .waddr (wr_idx_s),
        .wdata ({addr, in}),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    assign {fb_addr, fb_data} = rd_data_s;

    // Read and write pointers, wrapping modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else begin
            rd_ptr_r <= pop_s  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
            wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a drop outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

endmodule

// File: tb/tb_hack_screen_wq.sv
// Self-checking bench for hack_screen_wq: vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_hack_screen_wq;
    import hack_pkg::*;

`ifdef HACK_SCREEN_WQ_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [12:0] addr = 13'h0;
    logic [15:0] in = 16'h0;
    logic        stall;
    logic        fb_valid;
    logic [12:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_ready = 1'b0;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    hack_wq_entry_t mq[$];
    hack_wq_entry_t popped[$];
    bit             m_ovf = 1'b0;
    bit             m_pushed;
    bit             stab_en = 1'b0;

    hack_screen_wq #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load(load), .addr(addr), .in(in),
        .stall(stall), .fb_valid(fb_valid), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_ready(fb_ready), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: queue semantics straight from the write-queue rules.
    task automatic model_update(input bit l, input logic [12:0] a, input logic [15:0] d,
                                input bit r, input bit c, input bit rst);
        bit pop, full, co, drop;
        hack_wq_entry_t e;
        m_pushed = 1'b0;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            return;
        end
        pop  = (mq.size() != 0) && r;
        full = (mq.size() == DEPTH);
        co   = COAL && l && (mq.size() != 0) && (mq[$].addr == a) && !(mq.size() == 1 && pop);
        drop = 1'b0;
        if (co) begin
            e = mq[$];
            e.data = d;
            mq[$] = e;
        end
        if (pop) void'(mq.pop_front());
        if (l && !co) begin
            if (!full || pop) begin
                e.addr = a;
                e.data = d;
                mq.push_back(e);
                m_pushed = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    task automatic model_check();
        chk("valid", fb_valid, (mq.size() != 0));
        chk("stall", stall, (mq.size() == DEPTH));
        chk("ovf", ovf, m_ovf);
        if (mq.size() != 0) begin
            chk("head_addr", fb_addr, mq[0].addr);
            chk("head_data", fb_data, mq[0].data);
        end
    endtask

    // One clock: drive inputs, note the pre-edge head, advance, update and compare.
    task automatic step(input bit l, input logic [12:0] a, input logic [15:0] d,
                        input bit r, input bit c, input bit rst);
        bit pv;
        logic [12:0] pa;
        logic [15:0] pd;
        hack_wq_entry_t e;
        reset = rst; load = l; addr = a; in = d; fb_ready = r; ovf_clr = c;
        #1;
        pv = fb_valid; pa = fb_addr; pd = fb_data;
        if (fb_valid && r && !rst) begin
            e.addr = fb_addr;
            e.data = fb_data;
            popped.push_back(e);
        end
        @(posedge clk);
        #1;
        model_update(l, a, d, r, c, rst);
        model_check();
        if (stab_en && pv && !r && !rst && fb_valid) begin
            chk("stable_addr", fb_addr, pa);
            chk("stable_data", fb_data, pd);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (fb_valid && g < 40) begin
            step(1'b0, 13'h0, 16'h0, 1'b1, 1'b0, 1'b0);
            g++;
        end
        chk("drain_timeout", fb_valid, 1'b0);
    endtask

    typedef struct {
        bit          l;
        logic [12:0] a;
        logic [15:0] d;
        bit          r;
        bit          c;
        bit          ev;
        bit          es;
        bit          eo;
        logic [12:0] ea;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[17];
    hack_wq_entry_t exp_q[$];
    hack_wq_entry_t ent;

    initial begin
        // Expected DUT state after each row's clock edge.
        for (int i = 0; i < 5; i++) tbl[i] = '{0, 13'h0, 16'h0, 0, 0, 0, 0, 0, 13'h0, 16'h0};
        tbl[5] = '{1, 13'h0010, 16'hBEEF, 1, 0, 1, 0, 0, 13'h0010, 16'hBEEF};
        tbl[6] = '{0, 13'h0, 16'h0, 1, 0, 0, 0, 0, 13'h0, 16'h0};
        for (int i = 0; i < 8; i++)
            tbl[7+i] = '{1, 13'(i), 16'(16'h1000 + i), 0, 0, 1, (i == 7), 0, 13'h0, 16'h1000};
        tbl[15] = '{1, 13'h8, 16'h1008, 0, 0, 1, 1, 1, 13'h0, 16'h1000};
        tbl[16] = '{0, 13'h0, 16'h0, 0, 1, 1, 1, 0, 13'h0, 16'h1000};

        step(1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", fb_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ovf", ovf, 1'b0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].l, tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].c, 1'b0);
            chk($sformatf("tbl%0d_valid", i), fb_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].es);
            chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].eo);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_addr", i), fb_addr, tbl[i].ea);
                chk($sformatf("tbl%0d_data", i), fb_data, tbl[i].ed);
            end
        end

        // Full queue: push with a simultaneous pop keeps it full, no overflow.
        popped.delete();
        step(1'b1, 13'h1FFF, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        chk("fullpop_stall", stall, 1'b1);
        chk("fullpop_ovf", ovf, 1'b0);
        drain();
        chk("fullpop_count", popped.size(), 9);
        for (int i = 0; i < 8; i++)
            if (i < popped.size()) chk($sformatf("drain%0d", i), popped[i].data, 16'h1000 + i);
        if (popped.size() > 8) chk("drain_aaaa", popped[8].data, 16'hAAAA);

        // Toggling fb_ready during a 20-write burst; CPU holds its write while stalled.
        popped.delete();
        stab_en = 1'b1;
        begin
            int idx = 0;
            int g = 0;
            while (idx < 20 && g < 200) begin
                step(1'b1, 13'(13'h100 + idx), 16'(16'h5000 + idx), g[0], 1'b0, 1'b0);
                if (m_pushed) idx++;
                g++;
            end
            chk("burst_timeout", idx, 20);
        end
        drain();
        stab_en = 1'b0;
        chk("burst_count", popped.size(), 20);
        for (int i = 0; i < 20; i++)
            if (i < popped.size()) begin
                chk($sformatf("burst%0d_addr", i), popped[i].addr, 13'h100 + i);
                chk($sformatf("burst%0d_data", i), popped[i].data, 16'h5000 + i);
            end

        // Same-address writes: coalesced into the tail or queued separately.
        popped.delete();
        exp_q.delete();
        step(1'b1, 13'h20, 16'h1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 13'h20, 16'h2222, 1'b0, 1'b0, 1'b0);
        step(1'b1, 13'h21, 16'h3333, 1'b0, 1'b0, 1'b0);
`ifdef HACK_SCREEN_WQ_COALESCE_EN
        ent = '{13'h20, 16'h2222}; exp_q.push_back(ent);
        ent = '{13'h21, 16'h3333}; exp_q.push_back(ent);
`else
        ent = '{13'h20, 16'h1111}; exp_q.push_back(ent);
        ent = '{13'h20, 16'h2222}; exp_q.push_back(ent);
        ent = '{13'h21, 16'h3333}; exp_q.push_back(ent);
`endif
        drain();
        chk("coal_count", popped.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < popped.size()) chk($sformatf("coal%0d", i), popped[i], exp_q[i]);

        // Reset mid-operation discards queued entries and clears ovf.
        for (int i = 0; i < 9; i++) step(1'b1, 13'(13'h300 + i), 16'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ovf", ovf, 1'b1);
        step(1'b0, 13'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_valid", fb_valid, 1'b0);
        chk("mid_rst_ovf", ovf, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);

        // Randomized traffic on a narrow address range against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 13'(13'h40 + $urandom_range(0, 3)),
                 16'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
